// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB encodings and burst helpers for the bus arbiter.
// Master index width is sized for up to 16 requesters.
package ahb_bus_arbiter_pkg;

    localparam int HMASTER_WIDTH = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ARB_PARK   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

    // Fixed burst length in beats; 0 marks undefined-length INCR.
    function automatic logic [4:0] burst_len(input hburst_e burst);
        logic [4:0] len;
        case (burst)
            HBURST_SINGLE:                len = 5'd1;
            HBURST_INCR:                  len = 5'd0;
            HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
            default:                      len = 5'd16;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration signals between the requesting masters and the bus arbiter.
// The master modport is the requester/bus side, the slave modport is the arbiter.
interface ahb_bus_arbiter_if
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4
);

    logic [NUM_MASTERS-1:0]   hbusreq;
    logic [NUM_MASTERS-1:0]   hlock;
    htrans_e                  htrans;
    hburst_e                  hburst;
    logic                     hready;
    logic [NUM_MASTERS-1:0]   hgrant;
    logic [HMASTER_WIDTH-1:0] hmaster;
    logic                     hmastlock;
    logic [HMASTER_WIDTH-1:0] hmasterData;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmastlock, hmasterData
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmastlock, hmasterData
    );

endinterface

// File: rtl/ahb_bus_arbiter_rr_picker.sv
// Combinational round-robin pick: first asserted request after rr_ptr,
// wrapping, with rr_ptr itself considered last.
module ahb_bus_arbiter_rr_picker
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]   req,
    input  logic [HMASTER_WIDTH-1:0] rr_ptr,
    output logic [NUM_MASTERS-1:0]   grant,
    output logic [HMASTER_WIDTH-1:0] idx,
    output logic                     any_req
);

    logic [HMASTER_WIDTH:0]   shift;
    logic [NUM_MASTERS-1:0]   rot;
    logic [HMASTER_WIDTH:0]   first_off;
    logic                     first_found;
    logic [HMASTER_WIDTH:0]   idx_sum;
    logic [HMASTER_WIDTH:0]   idx_wrap;

    // rot[k] = req[(rr_ptr + 1 + k) mod NUM_MASTERS]
    assign shift = {1'b0, rr_ptr} + 1'b1;
    assign rot   = NUM_MASTERS'({req, req} >> shift);

    always_comb begin
        first_found = 1'b0;
        first_off   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!first_found && rot[k]) begin
                first_found = 1'b1;
                first_off   = (HMASTER_WIDTH + 1)'(k);
            end
        end
    end

    assign idx_sum  = shift + first_off;
    assign idx_wrap = (idx_sum >= (HMASTER_WIDTH + 1)'(NUM_MASTERS))
                    ? idx_sum - (HMASTER_WIDTH + 1)'(NUM_MASTERS)
                    : idx_sum;
    assign idx      = idx_wrap[HMASTER_WIDTH-1:0];
    assign any_req  = first_found;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
        assign grant[gi] = first_found && (idx == HMASTER_WIDTH'(gi));
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter: registered grant, address- and data-phase owner,
// with handover restricted to burst ends, idle cycles and released locks.
module ahb_bus_arbiter
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input logic               hclk,
    input logic               hresetn,
    ahb_bus_arbiter_if.slave  bus
);

    localparam logic [HMASTER_WIDTH-1:0] DEFAULT_IDX   = HMASTER_WIDTH'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0]   DEFAULT_GRANT = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    arb_state_e               state_reg, state_next;
    logic [NUM_MASTERS-1:0]   hgrant_reg, hgrant_next;
    logic [HMASTER_WIDTH-1:0] owner_reg, owner_next;
    logic [HMASTER_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
    logic [4:0]               beat_cnt_reg, beat_cnt_next;
    logic [HMASTER_WIDTH-1:0] hmaster_reg;
    logic                     hmastlock_reg;
    logic [HMASTER_WIDTH-1:0] hmaster_data_reg;

    logic [NUM_MASTERS-1:0]   pick_grant;
    logic [HMASTER_WIDTH-1:0] pick_idx;
    logic                     pick_any;

    logic [4:0] len;
    logic       owner_req;
    logic       owner_lock;
    logic       last_beat;
    logic       hand_pt;
    logic       rearb;

    ahb_bus_arbiter_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req     (bus.hbusreq),
        .rr_ptr  (rr_ptr_reg),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    assign len        = burst_len(bus.hburst);
    assign owner_req  = |(bus.hbusreq & hgrant_reg);
    assign owner_lock = |(bus.hlock & hgrant_reg);
    assign last_beat  = (bus.htrans == HTRANS_SEQ) && (len > 5'd1) && (beat_cnt_reg == len - 5'd1);

    assign hand_pt = bus.hready && (
                         (bus.htrans == HTRANS_IDLE)
                      || ((bus.htrans == HTRANS_NONSEQ) && (len == 5'd1))
                      || last_beat
                      || ((bus.hburst == HBURST_INCR) && !owner_req));

    always_comb begin
        state_next    = state_reg;
        hgrant_next   = hgrant_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        rearb         = 1'b0;

        if (bus.hready) begin
            if (bus.htrans == HTRANS_NONSEQ) begin
                beat_cnt_next = 5'd1;
            end else if (bus.htrans == HTRANS_SEQ) begin
                beat_cnt_next = beat_cnt_reg + 5'd1;
            end
        end

        case (state_reg)
            // The parked master issues no transfers of its own, so any ready cycle may hand over.
            ARB_PARK:   rearb = bus.hready;
            ARB_OWNED:  rearb = hand_pt;
            // Once hlock drops, the next completed transfer is still kept by the owner.
            ARB_LOCKED: begin
                if (!owner_lock && bus.hready && (bus.htrans != HTRANS_BUSY)) begin
                    state_next = ARB_OWNED;
                end
            end
            default:    state_next = ARB_PARK;
        endcase

        if (rearb) begin
            if (pick_any) begin
                hgrant_next = pick_grant;
                owner_next  = pick_idx;
                rr_ptr_next = pick_idx;
                state_next  = (|(bus.hlock & pick_grant)) ? ARB_LOCKED : ARB_OWNED;
            end else begin
                hgrant_next = DEFAULT_GRANT;
                owner_next  = DEFAULT_IDX;
                state_next  = ARB_PARK;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg        <= ARB_PARK;
            hgrant_reg       <= DEFAULT_GRANT;
            owner_reg        <= DEFAULT_IDX;
            rr_ptr_reg       <= DEFAULT_IDX;
            beat_cnt_reg     <= '0;
            hmaster_reg      <= DEFAULT_IDX;
            hmastlock_reg    <= 1'b0;
            hmaster_data_reg <= DEFAULT_IDX;
        end else begin
            state_reg    <= state_next;
            hgrant_reg   <= hgrant_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
            // Address phase follows the grant by one accepted transfer; data phase by one more.
            if (bus.hready) begin
                hmaster_reg      <= owner_reg;
                hmastlock_reg    <= owner_lock;
                hmaster_data_reg <= hmaster_reg;
            end
        end
    end

    assign bus.hgrant      = hgrant_reg;
    assign bus.hmaster     = hmaster_reg;
    assign bus.hmastlock   = hmastlock_reg;
    assign bus.hmasterData = hmaster_data_reg;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboarded bench for ahb_bus_arbiter: directed scenarios then randomized traffic,
// each cycle checked against a rule-level reference model.
module tb_ahb_bus_arbiter;
    import ahb_bus_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int DEF = 0;

    logic hclk    = 1'b0;
    logic hresetn = 1'b0;

    ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

    ahb_bus_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (DEF)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [N-1:0] grant;
        int           hm;
        bit           lk;
        int           hmd;
        string        tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int m_owner, m_rr, m_beats, m_hm, m_hmd;
    bit m_lk, m_parked, m_locked;

    function automatic int len_of(input hburst_e b);
        case (b)
            HBURST_SINGLE:               return 1;
            HBURST_INCR:                 return 0;
            HBURST_WRAP4, HBURST_INCR4:  return 4;
            HBURST_WRAP8, HBURST_INCR8:  return 8;
            default:                     return 16;
        endcase
    endfunction

    function automatic void model_reset();
        m_owner = DEF; m_rr = DEF; m_beats = 0;
        m_hm = DEF; m_hmd = DEF; m_lk = 0;
        m_parked = 1; m_locked = 0;
    endfunction

    function automatic void model_step(input logic [N-1:0] req, input logic [N-1:0] lk,
                                       input htrans_e tr, input hburst_e bu, input logic rdy);
        int len    = len_of(bu);
        int nb     = m_beats;
        int winner = -1;
        bit sw     = 0;
        if (rdy && tr == HTRANS_NONSEQ)   nb = 1;
        else if (rdy && tr == HTRANS_SEQ) nb = (m_beats + 1) % 32;
        if (rdy) begin
            if (m_parked) begin
                sw = 1;
            end else if (m_locked) begin
                if (!lk[m_owner] && tr != HTRANS_BUSY) m_locked = 0;
            end else begin
                sw = (tr == HTRANS_IDLE)
                  || (tr == HTRANS_NONSEQ && len == 1)
                  || (tr == HTRANS_SEQ && len > 1 && m_beats == len - 1)
                  || (len == 0 && !req[m_owner]);
            end
            m_hmd = m_hm;
            m_hm  = m_owner;
            m_lk  = lk[m_owner];
        end
        if (sw) begin
            for (int s = 1; s <= N; s++)
                if (winner < 0 && req[(m_rr + s) % N]) winner = (m_rr + s) % N;
            if (winner >= 0) begin
                m_owner = winner; m_rr = winner; m_parked = 0; m_locked = lk[winner];
            end else begin
                m_owner = DEF; m_parked = 1; m_locked = 0;
            end
        end
        m_beats = nb;
    endfunction

    function automatic void push_expect(input string tag);
        exp_t e;
        e.grant = '0;
        e.grant[m_owner] = 1'b1;
        e.hm  = m_hm;
        e.lk  = m_lk;
        e.hmd = m_hmd;
        e.tag = tag;
        exp_q.push_back(e);
    endfunction

    function automatic void cmp(input string what, input string tag,
                                input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s %s at %0t: got %0h want %0h", tag, what, $time, got, want);
        end
    endfunction

    // Monitor: every clock edge or reset assertion presents a fresh output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge hclk or negedge hresetn);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("hgrant",      e.tag, 32'(bus.hgrant),      32'(e.grant));
                cmp("hmaster",     e.tag, 32'(bus.hmaster),     32'(e.hm));
                cmp("hmastlock",   e.tag, 32'(bus.hmastlock),   32'(e.lk));
                cmp("hmasterData", e.tag, 32'(bus.hmasterData), 32'(e.hmd));
                $display("txn %-10s t=%0t grant=%b hmaster=%0d lock=%b hmasterData=%0d",
                         e.tag, $time, bus.hgrant, bus.hmaster, bus.hmastlock, bus.hmasterData);
            end
        end
    end

    task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] lk, input htrans_e tr,
                         input hburst_e bu, input logic rdy, input string tag);
        @(negedge hclk);
        hresetn     = 1'b1;
        bus.hbusreq = req;
        bus.hlock   = lk;
        bus.htrans  = tr;
        bus.hburst  = bu;
        bus.hready  = rdy;
        model_step(req, lk, tr, bu, rdy);
        push_expect(tag);
    endtask

    // Asserts reset away from both clock edges; released by the next cycle() call.
    task automatic async_reset();
        @(negedge hclk);
        model_reset();
        push_expect("rst_async");
        push_expect("rst_hold");
        #2 hresetn = 1'b0;
    endtask

    task automatic run_random(input int cycles);
        logic [N-1:0] req = '0;
        logic [N-1:0] lk  = '0;
        htrans_e tr = HTRANS_IDLE;
        hburst_e bu = HBURST_SINGLE;
        logic rdy = 1'b1;
        int target = 0;
        int issued = 0;
        bit active = 0;
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            if ($urandom_range(0, 9) == 0) lk = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            // A stalled transfer is re-presented unchanged.
            if (rdy) begin
                if (active && issued >= target) active = 0;
                if (!active) begin
                    if ($urandom_range(0, 1) == 0) begin
                        bu     = hburst_e'($urandom_range(0, 7));
                        tr     = HTRANS_NONSEQ;
                        active = 1;
                        issued = 0;
                        target = (len_of(bu) == 0) ? int'($urandom_range(1, 6)) : len_of(bu);
                    end else begin
                        tr = HTRANS_IDLE;
                    end
                end else begin
                    tr = ($urandom_range(0, 4) == 0) ? HTRANS_BUSY : HTRANS_SEQ;
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            cycle(req, lk, tr, bu, rdy, "random");
            if (rdy && tr == HTRANS_NONSEQ)   issued = 1;
            else if (rdy && tr == HTRANS_SEQ) issued++;
        end
    endtask

    initial begin
        model_reset();
        bus.hbusreq = '0;
        bus.hlock   = '0;
        bus.htrans  = HTRANS_IDLE;
        bus.hburst  = HBURST_SINGLE;
        bus.hready  = 1'b1;
        repeat (3) @(negedge hclk);

        // Parked with no requests
        repeat (10) cycle(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, "t1_park");

        // Two requesters alternating single transfers
        for (int i = 0; i < 8; i++)
            cycle(4'b0110, 4'b0000, (i % 2 == 0) ? HTRANS_NONSEQ : HTRANS_IDLE,
                  HBURST_SINGLE, 1'b1, "t2_alt");

        // INCR8 with wait states, competing request from beat 2
        repeat (2) cycle(4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, "t3_grab");
        cycle(4'b0100, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1, "t3_b1");
        repeat (2) cycle(4'b1100, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b1, "t3_b2_3");
        repeat (3) cycle(4'b1100, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b0, "t3_wait");
        repeat (5) cycle(4'b1100, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b1, "t3_b4_8");
        repeat (2) cycle(4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, "t3_after");

        // Locked sequence by master 1 with competitors
        repeat (2) cycle(4'b0010, 4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1, "t4_grab");
        repeat (3) cycle(4'b0111, 4'b0010, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, "t4_locked");
        repeat (4) cycle(4'b0111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, "t4_release");

        // Undefined-length INCR ended by dropping the request
        repeat (2) cycle(4'b0001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, "t5_grab");
        cycle(4'b1001, 4'b0000, HTRANS_NONSEQ, HBURST_INCR, 1'b1, "t5_b1");
        repeat (4) cycle(4'b1001, 4'b0000, HTRANS_SEQ, HBURST_INCR, 1'b1, "t5_seq");
        cycle(4'b1000, 4'b0000, HTRANS_SEQ, HBURST_INCR, 1'b1, "t5_drop");
        repeat (2) cycle(4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, "t5_after");

        // Reset in the middle of an INCR16; the beat count must restart from zero
        repeat (2) cycle(4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, "t6_grab");
        cycle(4'b0100, 4'b0000, HTRANS_NONSEQ, HBURST_INCR16, 1'b1, "t6_b1");
        repeat (5) cycle(4'b0100, 4'b0000, HTRANS_SEQ, HBURST_INCR16, 1'b1, "t6_seq");
        async_reset();
        repeat (18) cycle(4'b1100, 4'b0000, HTRANS_SEQ, HBURST_INCR16, 1'b1, "t6_resume");

        run_random(1500);

        repeat (2) @(negedge hclk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
